// File: rtl/cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_pkg
// Description : Shared types and constants for the CAVLC coefficient scan
//               and level encoder stages: coefficient width, scan FSM
//               state encoding, the LIFO entry record and the trailing-ones
//               limit, plus a helper that masks trailing-one sign bits.
// Revision    : 1.0 - initial release
// ============================================================================
package cavlc_pkg;

    localparam int COEF_W = 15;
    localparam int MAX_T1 = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } scan_state_e;

    // One stacked nonzero coefficient: its value and the number of zeros
    // between it and the next lower-index nonzero (or DC, for the lowest).
    typedef struct packed {
        logic [COEF_W-1:0] level;
        logic [3:0]        run_before;
    } coef_entry_t;

    // Keep only the low n sign bits of the trailing-one sign history.
    function automatic logic [2:0] t1_mask(input logic [1:0] n);
        logic [2:0] m;
        case (n)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_coeff_lifo.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_coeff_lifo
// Description : 16-deep stack of coef_entry_t with a combinational top.
//               Ports: clk/rst (async, active-high, clears the pointer),
//               push + din, pop, top (entry at ptr-1, zero when empty),
//               ptr (number of stored entries, 0..16).
//               Push and pop together replace the top entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_coeff_lifo
    import cavlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  coef_entry_t din,
    output coef_entry_t top,
    output logic [4:0]  ptr
);

    coef_entry_t r_mem [16];
    logic [4:0]  r_ptr;

    logic        w_empty;
    logic        w_full;
    logic        w_do_push;
    logic        w_do_pop;
    logic [3:0]  w_top_addr;
    logic [3:0]  w_wr_addr;

    assign w_empty    = (r_ptr == 5'd0);
    assign w_full     = (r_ptr == 5'd16);
    assign w_do_pop   = pop && !w_empty;
    assign w_do_push  = push && (!w_full || w_do_pop);
    assign w_top_addr = r_ptr[3:0] - 4'd1;
    // A simultaneous pop frees the top slot, so the push overwrites it.
    assign w_wr_addr  = w_do_pop ? w_top_addr : r_ptr[3:0];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 5'd0;
        end else if (w_do_push && !w_do_pop) begin
            r_ptr <= r_ptr + 5'd1;
        end else if (w_do_pop && !w_do_push) begin
            r_ptr <= r_ptr - 5'd1;
        end
    end

    assign top = w_empty ? '0 : r_mem[w_top_addr];
    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/cavlc_coeff_scan.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_coeff_scan
// Description : Latches 16 zig-zag coefficients on start, scans them one per
//               cycle (16 cycles), then reports the block summary and
//               streams the nonzero coefficients highest-index first.
//               Ports: clk, rst (async, active-high), start, zz_00..zz_15;
//               busy, done; summary_valid with total_coeff, trailing_ones,
//               trailing_sign, total_zeros; entry stream ent_valid/ent_ready
//               with ent_level, ent_run_before, ent_zeros_left, ent_t1,
//               ent_last.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_coeff_scan
    import cavlc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [COEF_W-1:0] zz_00,
    input  logic signed [COEF_W-1:0] zz_01,
    input  logic signed [COEF_W-1:0] zz_02,
    input  logic signed [COEF_W-1:0] zz_03,
    input  logic signed [COEF_W-1:0] zz_04,
    input  logic signed [COEF_W-1:0] zz_05,
    input  logic signed [COEF_W-1:0] zz_06,
    input  logic signed [COEF_W-1:0] zz_07,
    input  logic signed [COEF_W-1:0] zz_08,
    input  logic signed [COEF_W-1:0] zz_09,
    input  logic signed [COEF_W-1:0] zz_10,
    input  logic signed [COEF_W-1:0] zz_11,
    input  logic signed [COEF_W-1:0] zz_12,
    input  logic signed [COEF_W-1:0] zz_13,
    input  logic signed [COEF_W-1:0] zz_14,
    input  logic signed [COEF_W-1:0] zz_15,
    output logic                     busy,
    output logic                     summary_valid,
    output logic [4:0]               total_coeff,
    output logic [1:0]               trailing_ones,
    output logic [2:0]               trailing_sign,
    output logic [3:0]               total_zeros,
    output logic                     ent_valid,
    input  logic                     ent_ready,
    output logic signed [COEF_W-1:0] ent_level,
    output logic [3:0]               ent_run_before,
    output logic [3:0]               ent_zeros_left,
    output logic                     ent_t1,
    output logic                     ent_last,
    output logic                     done
);

    logic [COEF_W-1:0] w_zz   [16];
    logic [COEF_W-1:0] r_coef [16];

    assign w_zz[0]  = zz_00;
    assign w_zz[1]  = zz_01;
    assign w_zz[2]  = zz_02;
    assign w_zz[3]  = zz_03;
    assign w_zz[4]  = zz_04;
    assign w_zz[5]  = zz_05;
    assign w_zz[6]  = zz_06;
    assign w_zz[7]  = zz_07;
    assign w_zz[8]  = zz_08;
    assign w_zz[9]  = zz_09;
    assign w_zz[10] = zz_10;
    assign w_zz[11] = zz_11;
    assign w_zz[12] = zz_12;
    assign w_zz[13] = zz_13;
    assign w_zz[14] = zz_14;
    assign w_zz[15] = zz_15;

    scan_state_e r_state;
    logic [4:0]  r_cnt;       // scan index in SCAN, entries emitted in EMIT
    logic [3:0]  r_zcnt;
    logic [3:0]  r_last_idx;
    logic [4:0]  r_tc;
    logic [1:0]  r_t1;
    logic [2:0]  r_hist;      // bit 0 = sign of the most recent +/-1
    logic [3:0]  r_zl;

    logic              w_accept;
    logic              w_xfer;
    logic [COEF_W-1:0] w_cur;
    logic              w_nz;
    logic              w_is_one;
    logic [3:0]        w_zcnt_n;
    logic [4:0]        w_tc_n;
    logic [3:0]        w_last_n;
    logic [1:0]        w_t1_n;
    logic [2:0]        w_hist_n;
    logic [3:0]        w_tz_n;

    coef_entry_t w_push_data;
    coef_entry_t w_top;
    logic [4:0]  w_ptr;
    logic        w_push;

    // A start coinciding with done is dropped so the packer always sees a
    // gap between blocks.
    assign w_accept = start && (r_state == IDLE) && !done;
    assign w_xfer   = ent_valid && ent_ready;

    assign w_cur    = r_coef[r_cnt[3:0]];
    assign w_nz     = |w_cur;
    assign w_is_one = (w_cur == COEF_W'(1)) || (w_cur == '1);

    always_comb begin
        w_zcnt_n = w_nz ? 4'd0 : r_zcnt + 4'd1;
        w_tc_n   = r_tc + {4'd0, w_nz};
        w_last_n = w_nz ? r_cnt[3:0] : r_last_idx;
        w_t1_n   = r_t1;
        w_hist_n = r_hist;
        if (w_nz) begin
            if (w_is_one) begin
                w_t1_n   = (r_t1 == 2'(MAX_T1)) ? r_t1 : r_t1 + 2'd1;
                w_hist_n = {r_hist[1:0], w_cur[COEF_W-1]};
            end else begin
                w_t1_n   = 2'd0;
            end
        end
        // Modulo-16 arithmetic is exact here: the true result is 0..15,
        // including the full block (15 + 1 - 16 = 0).
        w_tz_n = (w_tc_n == 5'd0) ? 4'd0
                                  : w_last_n + 4'd1 - w_tc_n[3:0];
    end

    assign w_push               = (r_state == SCAN) && w_nz;
    assign w_push_data.level      = w_cur;
    assign w_push_data.run_before = r_zcnt;

    cavlc_coeff_lifo u_lifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_xfer),
        .din  (w_push_data),
        .top  (w_top),
        .ptr  (w_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_coef <= w_zz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 5'd0;
            r_zcnt        <= 4'd0;
            r_last_idx    <= 4'd0;
            r_tc          <= 5'd0;
            r_t1          <= 2'd0;
            r_hist        <= 3'd0;
            r_zl          <= 4'd0;
            busy          <= 1'b0;
            summary_valid <= 1'b0;
            total_coeff   <= 5'd0;
            trailing_ones <= 2'd0;
            trailing_sign <= 3'd0;
            total_zeros   <= 4'd0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Clears the summary after an all-zero block's done cycle.
                    summary_valid <= 1'b0;
                    if (w_accept) begin
                        busy       <= 1'b1;
                        r_cnt      <= 5'd0;
                        r_zcnt     <= 4'd0;
                        r_last_idx <= 4'd0;
                        r_tc       <= 5'd0;
                        r_t1       <= 2'd0;
                        r_hist     <= 3'd0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_zcnt     <= w_zcnt_n;
                    r_tc       <= w_tc_n;
                    r_last_idx <= w_last_n;
                    r_t1       <= w_t1_n;
                    r_hist     <= w_hist_n;
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) begin
                        // Summary uses the next-state values so that the
                        // final coefficient is already included.
                        summary_valid <= 1'b1;
                        total_coeff   <= w_tc_n;
                        trailing_ones <= w_t1_n;
                        trailing_sign <= w_hist_n & t1_mask(w_t1_n);
                        total_zeros   <= w_tz_n;
                        r_zl          <= w_tz_n;
                        r_cnt         <= 5'd0;
                        if (w_tc_n == 5'd0) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (w_xfer) begin
                        r_zl  <= r_zl - w_top.run_before;
                        r_cnt <= r_cnt + 5'd1;
                        if (w_ptr == 5'd1) begin
                            done          <= 1'b1;
                            busy          <= 1'b0;
                            summary_valid <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Entry fields are forced to zero whenever no entry is being offered.
    assign ent_valid      = (r_state == EMIT);
    assign ent_level      = ent_valid ? w_top.level : '0;
    assign ent_run_before = ent_valid ? w_top.run_before : 4'd0;
    assign ent_zeros_left = ent_valid ? r_zl : 4'd0;
    assign ent_t1         = ent_valid && (r_cnt < {3'd0, trailing_ones});
    assign ent_last       = ent_valid && (w_ptr == 5'd1);

endmodule
`default_nettype wire

// File: tb/tb_cavlc_coeff_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_cavlc_coeff_scan
// Description : Self-checking bench for cavlc_coeff_scan. Blocks are checked
//               against a reference model that derives the summary and the
//               entry list directly from the list of nonzero positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cavlc_coeff_scan;

    typedef logic signed [14:0] blk_t [16];

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [14:0] zz [16];
    logic               busy;
    logic               summary_valid;
    logic [4:0]         total_coeff;
    logic [1:0]         trailing_ones;
    logic [2:0]         trailing_sign;
    logic [3:0]         total_zeros;
    logic               ent_valid;
    logic               ent_ready;
    logic signed [14:0] ent_level;
    logic [3:0]         ent_run_before;
    logic [3:0]         ent_zeros_left;
    logic               ent_t1;
    logic               ent_last;
    logic               done;

    int vectors;
    int miscompares;

    // Reference model outputs
    int                 exp_tc;
    int                 exp_t1;
    logic [2:0]         exp_ts;
    int                 exp_tz;
    logic signed [14:0] exp_lvl [16];
    int                 exp_run [16];
    int                 exp_zl  [16];
    bit                 exp_et1 [16];

    cavlc_coeff_scan dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .zz_00          (zz[0]),
        .zz_01          (zz[1]),
        .zz_02          (zz[2]),
        .zz_03          (zz[3]),
        .zz_04          (zz[4]),
        .zz_05          (zz[5]),
        .zz_06          (zz[6]),
        .zz_07          (zz[7]),
        .zz_08          (zz[8]),
        .zz_09          (zz[9]),
        .zz_10          (zz[10]),
        .zz_11          (zz[11]),
        .zz_12          (zz[12]),
        .zz_13          (zz[13]),
        .zz_14          (zz[14]),
        .zz_15          (zz[15]),
        .busy           (busy),
        .summary_valid  (summary_valid),
        .total_coeff    (total_coeff),
        .trailing_ones  (trailing_ones),
        .trailing_sign  (trailing_sign),
        .total_zeros    (total_zeros),
        .ent_valid      (ent_valid),
        .ent_ready      (ent_ready),
        .ent_level      (ent_level),
        .ent_run_before (ent_run_before),
        .ent_zeros_left (ent_zeros_left),
        .ent_t1         (ent_t1),
        .ent_last       (ent_last),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entries are listed highest index first; each run is the gap down to
    // the next lower nonzero (or to index -1 for the lowest one).
    task automatic compute_model(input blk_t c);
        int nzi[$];
        int zl;
        int idx;
        int lower;
        nzi = {};
        for (int i = 0; i < 16; i++) if (c[i] != 0) nzi.push_back(i);
        exp_tc = nzi.size();
        exp_tz = (exp_tc == 0) ? 0 : nzi[exp_tc-1] + 1 - exp_tc;
        exp_t1 = 0;
        exp_ts = 3'b000;
        for (int k = 0; k < exp_tc && k < 3; k++) begin
            idx = nzi[exp_tc-1-k];
            if (exp_t1 == k && (c[idx] == 1 || c[idx] == -1)) begin
                exp_ts[k] = (c[idx] < 0);
                exp_t1++;
            end
        end
        zl = exp_tz;
        for (int k = 0; k < exp_tc; k++) begin
            idx        = nzi[exp_tc-1-k];
            lower      = (k == exp_tc-1) ? -1 : nzi[exp_tc-2-k];
            exp_lvl[k] = c[idx];
            exp_run[k] = idx - lower - 1;
            exp_zl[k]  = zl;
            exp_et1[k] = (k < exp_t1);
            zl         = zl - exp_run[k];
        end
    endtask

    // rmode: 0 = ready always high, 1 = pattern 0,1,0,0,1, 2 = random.
    task automatic run_block(input blk_t c, input int rmode,
                             input bit poke_start, input bit start_at_done);
        int  k;
        int  cyc;
        int  ph;
        bit  rdy;
        compute_model(c);
        for (int i = 0; i < 16; i++) zz[i] = c[i];
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        for (int s = 1; s <= 16; s++) begin
            ent_ready = 1'($urandom);
            vectors++;
            if (busy !== 1'b1 || summary_valid !== 1'b0 || ent_valid !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_flags cyc=%0d: busy/sv/ev/done=%b%b%b%b, required 1000",
                         cyc, busy, summary_valid, ent_valid, done);
            end
            step();
            cyc++;
        end
        ent_ready = 1'b0;
        vectors++;
        if (summary_valid !== 1'b1 || total_coeff !== 5'(exp_tc) || trailing_ones !== 2'(exp_t1) ||
            trailing_sign !== exp_ts || total_zeros !== 4'(exp_tz)) begin
            miscompares++;
            $display("FAIL summary: sv=%b tc=%0d t1=%0d ts=%b tz=%0d, required sv=1 tc=%0d t1=%0d ts=%b tz=%0d",
                     summary_valid, total_coeff, trailing_ones, trailing_sign, total_zeros,
                     exp_tc, exp_t1, exp_ts, exp_tz);
        end
        if (exp_tc == 0) begin
            vectors++;
            if (done !== 1'b1 || ent_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_done: done=%b ent_valid=%b, required 1 0", done, ent_valid);
            end
            step();
            vectors++;
            if (busy !== 1'b0 || summary_valid !== 1'b0 || done !== 1'b0 || ent_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_after: busy/sv/done/ev=%b%b%b%b, required 0000",
                         busy, summary_valid, done, ent_valid);
            end
            return;
        end
        k  = 0;
        ph = 0;
        while (k < exp_tc && cyc < 17 + 200) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (ph % 5 == 1) || (ph % 5 == 4);
                default: rdy = 1'($urandom);
            endcase
            ent_ready = rdy;
            if (poke_start && cyc == 18) begin
                for (int i = 0; i < 16; i++) zz[i] = 15'sd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            vectors++;
            if (ent_valid !== 1'b1 || done !== 1'b0 || summary_valid !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL emit_flags k=%0d: ev/done/sv/busy=%b%b%b%b, required 1011",
                         k, ent_valid, done, summary_valid, busy);
            end
            vectors++;
            if (ent_level !== exp_lvl[k] || ent_run_before !== 4'(exp_run[k]) ||
                ent_zeros_left !== 4'(exp_zl[k]) || ent_t1 !== exp_et1[k] ||
                ent_last !== (k == exp_tc-1)) begin
                miscompares++;
                $display("FAIL entry k=%0d: lvl=%0d run=%0d zl=%0d t1=%b last=%b, required lvl=%0d run=%0d zl=%0d t1=%b last=%b",
                         k, ent_level, ent_run_before, ent_zeros_left, ent_t1, ent_last,
                         exp_lvl[k], exp_run[k], exp_zl[k], exp_et1[k], (k == exp_tc-1));
            end
            if (rdy) k++;
            step();
            cyc++;
            ph++;
        end
        ent_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if (k < exp_tc) begin
            miscompares++;
            $display("FAIL emit_timeout: %0d entries accepted, required %0d", k, exp_tc);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || summary_valid !== 1'b0 || ent_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_cycle: done/busy/sv/ev=%b%b%b%b, required 1000",
                     done, busy, summary_valid, ent_valid);
        end
        if (rmode == 0) begin
            vectors++;
            if (cyc != 17 + exp_tc) begin
                miscompares++;
                $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, 17 + exp_tc);
            end
        end
        if (start_at_done) begin
            for (int i = 0; i < 16; i++) zz[i] = 15'sd5;
            start = 1'b1;
        end
        step();
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic rand_block(output blk_t c);
        int r;
        int dens;
        dens = $urandom_range(0, 100);
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 99);
            if (r >= dens)      c[i] = 15'sd0;
            else begin
                r = $urandom_range(0, 99);
                if (r < 60)      c[i] = ($urandom_range(0, 1) == 1) ? 15'sd1 : -15'sd1;
                else if (r < 90) c[i] = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(2, 9))
                                                                    : -15'($urandom_range(2, 9));
                else begin
                    c[i] = 15'($urandom);
                    if (c[i] == 0) c[i] = -15'sd16384;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        vectors++;
        if ({busy, summary_valid, total_coeff, trailing_ones, trailing_sign, total_zeros,
             ent_valid, ent_level, ent_run_before, ent_zeros_left, ent_t1, ent_last, done} !== 43'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b sv=%b tc=%0d ev=%b done=%b, required all 0",
                     busy, summary_valid, total_coeff, ent_valid, done);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_example();
        blk_t c;
        c = '{15'sd0, 15'sd3, -15'sd1, 15'sd0, 15'sd0, -15'sd1, 15'sd1, 15'sd0,
              15'sd1, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
        run_block(c, 0, 1'b0, 1'b0);
    endtask

    task automatic test_all_zero();
        blk_t c;
        for (int i = 0; i < 16; i++) c[i] = 15'sd0;
        run_block(c, 0, 1'b0, 1'b0);
    endtask

    task automatic test_all_ones();
        blk_t c;
        for (int i = 0; i < 16; i++) c[i] = 15'sd1;
        run_block(c, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sparse();
        blk_t c;
        for (int i = 0; i < 16; i++) c[i] = 15'sd0;
        c[0]  = 15'sd7;
        c[15] = -15'sd2;
        run_block(c, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        blk_t c;
        c = '{15'sd0, 15'sd3, -15'sd1, 15'sd0, 15'sd0, -15'sd1, 15'sd1, 15'sd0,
              15'sd1, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
        run_block(c, 1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        blk_t c;
        rand_block(c);
        c[3] = -15'sd4;
        run_block(c, 0, 1'b0, 1'b1);
        // The start raised in the done cycle must have been dropped.
        vectors++;
        if (busy !== 1'b0 || ent_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: busy=%b ev=%b, required 0 0", busy, ent_valid);
        end
        rand_block(c);
        run_block(c, 0, 1'b0, 1'b0);
        rand_block(c);
        run_block(c, 2, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        blk_t c;
        int   seen_done;
        rand_block(c);
        c[15] = 15'sd9;
        for (int i = 0; i < 16; i++) zz[i] = c[i];
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, summary_valid, total_coeff, trailing_ones, trailing_sign, total_zeros,
             ent_valid, ent_level, ent_run_before, ent_zeros_left, ent_t1, ent_last, done} !== 43'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b sv=%b tc=%0d ev=%b done=%b, required all 0",
                     busy, summary_valid, total_coeff, ent_valid, done);
        end
        seen_done = 0;
        repeat (3) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        rst = 1'b0;
        repeat (20) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: %0d cycles with done/busy, required 0", seen_done);
        end
        rand_block(c);
        run_block(c, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        blk_t c;
        for (int n = 0; n < 30; n++) begin
            rand_block(c);
            run_block(c, n % 3, (n % 4) == 1, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        ent_ready   = 1'b0;
        for (int i = 0; i < 16; i++) zz[i] = 15'sd0;
        test_reset();
        test_example();
        test_all_zero();
        test_all_ones();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cavlc_coeff_scan.md
# cavlc_coeff_scan

Analysis stage directly downstream of the 4x4 zig-zag register stage in the CAVLC path. It latches 16 zig-zag-ordered coefficients on `start` and scans them in 16 cycles. It produces the block summary (TotalCoeff, TrailingOnes, trailing signs, TotalZeros), then streams every nonzero coefficient in reverse scan order with its run_before and zeros_left over a valid/ready handshake. The CAVLC bitstream packer consumes both outputs.

## Interface
- `COEF_W`, 15, coefficient width (two's complement)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  pulse; latch `zz_00..zz_15` and begin a block
- `zz_00 .. zz_15`  in  COEF_W each, signed  coefficients in zig-zag order; index 0 is DC/lowest frequency
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `summary_valid`  out  1  summary fields valid; held until `done`
- `total_coeff`  out  5  nonzero count, 0..16
- `trailing_ones`  out  2  0..3
- `trailing_sign`  out  3  bit k = sign of the k-th trailing one in emission order; 1 = negative; unused bits 0
- `total_zeros`  out  4  zeros below the highest nonzero
- `ent_valid`  out  1  entry available
- `ent_ready`  in  1  consumer accepts the entry
- `ent_level`  out  COEF_W signed  coefficient value
- `ent_run_before`  out  4  zeros between this coefficient and the next lower-index nonzero; for the lowest coefficient, zeros below it
- `ent_zeros_left`  out  4  zeros remaining before this entry's run is consumed
- `ent_t1`  out  1  entry is one of the trailing ones
- `ent_last`  out  1  final entry of the block
- `done`  out  1  one-cycle pulse at block end

## Operation
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - `start` latches inputs; the counter is set to 0; next state is SCAN.
  - `start` is ignored in every state other than IDLE.
- SCAN: one coefficient per cycle, index 0 up to 15.
  - On a zero, `zcnt++`.
  - On a nonzero, push {level, run_before=`zcnt`} into the LIFO, set `zcnt=0`, set `last_idx=i`, and `total_coeff++`.
  - Trailing ones: on a ±1, `t1 = min(t1+1, 3)` and its sign is shifted into the sign history. On any other nonzero, `t1 = 0`.
- End of SCAN:
  - `total_zeros = last_idx + 1 - total_coeff`, or 0 when there is no nonzero.
  - `trailing_sign` is taken from the signs of the top `t1` entries.
  - If `total_coeff == 0`: assert `summary_valid` and `done` for one cycle, then return to IDLE.
  - Otherwise go to EMIT.
- EMIT: pop the LIFO top, i.e. the highest index first.
  - `ent_zeros_left` starts at `total_zeros` and decreases by `ent_run_before` after each handshake.
  - `ent_t1` is set for the first `trailing_ones` entries.
  - `ent_last` is set on entry number `total_coeff`.
- Handshake:
  - A transfer happens when `ent_valid && ent_ready`.
  - `ent_valid` and all `ent_*` fields are held stable until the transfer.
  - `ent_ready` has no effect outside EMIT.
- After the `ent_last` transfer, `done` pulses in the next cycle. In that same cycle the block returns to IDLE and `busy` and `summary_valid` fall.
- All counters are saturation-free by construction: `total_coeff` has 5 bits, `zcnt`, `run_before` and `zeros_left` each have 4 bits, and at most 15 zeros can occur.

## Timing
- Reset (async): state=IDLE, LIFO pointer=0, all outputs 0.
- Reset mid-SCAN or mid-EMIT aborts the block. No `done` pulse is produced.
- Let `start` be sampled at cycle 0:
  - Cycles 1..16 are SCAN and `busy` is high.
  - Cycle 17: `summary_valid` goes high and, if nonzero coefficients exist, the first `ent_valid` is asserted.
- Throughput is one entry per cycle with `ent_ready` held high.
- Minimum block time: 17 + total_coeff cycles, plus the 1-cycle `done` pulse.
- A `start` in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after `done`.

## Structure
- `cavlc_pkg` contains:
  - `COEF_W`
  - the `scan_state_e` enum (IDLE/SCAN/EMIT)
  - the packed struct `coef_entry_t` {level, run_before}
  - the constant `MAX_T1 = 3`
- Sub-module `cavlc_coeff_lifo`: 16-deep stack of `coef_entry_t` with push/pop/pointer and a combinational top output. It is also reused by the level encoder.

## Test plan
- Zig-zag block 0,3,-1,0,0,-1,1,0,1,0,0,0,0,0,0,0 with `ent_ready`=1:
  - Summary: total_coeff=5, trailing_ones=3, trailing_sign=3'b100, total_zeros=4.
  - Entries (level/run/zeros_left): 1/1/4, 1/0/3, -1/2/3, -1/0/1, 3/1/1. The first three have `ent_t1`; the fifth has `ent_last`.
- All-zero block:
  - At cycle 17: `summary_valid`=1, total_coeff=0, `done`=1.
  - `ent_valid` never rises; `busy`=0 at cycle 18.
- All 16 coefficients = 1:
  - Summary: total_coeff=16, trailing_ones=3, total_zeros=0.
  - 16 entries, all with run_before=0. `done` occurs 17 + 16 cycles after `start`.
- Block 7,0,...,0,-2 (index 15 = -2):
  - Summary: total_coeff=2, trailing_ones=0, total_zeros=14.
  - Entries: -2/14/14, then 7/0/0 with `ent_last`.
- Backpressure: the first block with `ent_ready` toggling 0,1,0,0,1,…:
  - Fields stay stable while `ent_ready`=0; there is no loss or duplication.
  - A `start` pulse during EMIT is ignored.
- Async `rst` asserted at cycle 10 of SCAN:
  - All outputs go to 0 immediately with no `done`.
  - A new block started after release produces correct results.
